// File: rtl/avago28_cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : avago28_cdc_pkg
//  Purpose  : Shared constants and helpers for the avago28 CDC synchroniser
//             family (legal stage range, filter limit, counter width helper).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package avago28_cdc_pkg;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int FILTER_CYCLES_MAX = 255;

  // Width needed to hold values 0..max_count, never less than one bit
  // (equivalent to max(1, clog2(max_count+1))).
  function automatic int cnt_width(input int max_count);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_count) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage : avago28_cdc_pkg
`default_nettype wire

// File: rtl/avago28_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module   : avago28_sync_chain
//  Purpose  : Plain resettable flop chain used as the metastability
//             synchroniser. Nothing but flops lives here so that sync-cell
//             attributes / dont_touch can be applied to this module alone,
//             and a library reset-capable sync cell can be swapped in here.
//  Ports    : clk    - destination clock
//             rst_n  - asynchronous active-low reset
//             i_d    - asynchronous input bits (WIDTH)
//             o_q    - synchronised output, last stage of the chain (WIDTH)
//  Revision : 1.0 - initial release
// ============================================================================
module avago28_sync_chain
  import avago28_cdc_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("avago28_sync_chain: STAGES out of legal range");
  end

  // Stage 0 is the capture flop; stage STAGES-1 feeds the consumer.
  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= {STAGES{RESET_VAL}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule : avago28_sync_chain
`default_nettype wire

// File: rtl/avago28_nxsync_filt.sv
`default_nettype none
// ============================================================================
//  Module   : avago28_nxsync_filt
//  Purpose  : Multi-channel synchroniser for quasi-static bits entering the
//             dstclk domain, with a per-channel stability filter and
//             registered rise/fall pulses.
//  Ports    : dstclk     - destination clock
//             dstrst_n   - asynchronous active-low reset
//             data_in    - asynchronous inputs, one independent bit/channel
//             data_out   - synchronised, filtered level
//             rise_pulse - one-cycle pulse when data_out goes 0->1
//             fall_pulse - one-cycle pulse when data_out goes 1->0
//  Revision : 1.0 - initial release
// ============================================================================
module avago28_nxsync_filt
  import avago28_cdc_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter int                SYNC_STAGES   = 3,
  parameter int                FILTER_CYCLES = 0,
  parameter logic [NUM_CH-1:0] RESET_VAL     = {NUM_CH{1'b0}}
) (
  input  logic              dstclk,
  input  logic              dstrst_n,
  input  logic [NUM_CH-1:0] data_in,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("avago28_nxsync_filt: NUM_CH must be at least 1");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("avago28_nxsync_filt: SYNC_STAGES must be 2..4");
  end
  if (FILTER_CYCLES < 0 || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filter
    $error("avago28_nxsync_filt: FILTER_CYCLES must be 0..255");
  end

  localparam int                c_cnt_w   = cnt_width(FILTER_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_CYCLES);

  logic [NUM_CH-1:0] w_sync_q;

  avago28_sync_chain #(
    .WIDTH     (NUM_CH),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync_chain (
    .clk   (dstclk),
    .rst_n (dstrst_n),
    .i_d   (data_in),
    .o_q   (w_sync_q)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic               r_out;
    logic               r_rise;
    logic               r_fall;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_diff;
    logic               w_take;

    // The count tracks how many consecutive edges the synchronised value
    // has already disagreed with data_out. The change is accepted on the
    // edge where it has disagreed FILTER_CYCLES times before, i.e. on the
    // (FILTER_CYCLES+1)-th consecutive disagreement. Because the counter
    // clears on acceptance or agreement it tops out at FILTER_CYCLES.
    assign w_diff = w_sync_q[ch] ^ r_out;
    assign w_take = w_diff && (r_cnt == c_cnt_max);

    always_ff @(posedge dstclk or negedge dstrst_n) begin
      if (!dstrst_n) begin
        r_out  <= RESET_VAL[ch];
        r_cnt  <= '0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        // Pulses are registered alongside the data_out update so they are
        // aligned with the new level and last exactly one cycle.
        r_rise <= w_take &  w_sync_q[ch];
        r_fall <= w_take & ~w_sync_q[ch];
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_take) begin
          r_out <= w_sync_q[ch];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end

    assign data_out[ch]   = r_out;
    assign rise_pulse[ch] = r_rise;
    assign fall_pulse[ch] = r_fall;
  end : g_ch

endmodule : avago28_nxsync_filt
`default_nettype wire

// File: tb/tb_avago28_nxsync_filt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avago28_nxsync_filt
//  Purpose  : Self-checking bench for avago28_nxsync_filt. Three instances
//             with different parameter sets run side by side:
//               a: SYNC_STAGES=3, FILTER_CYCLES=0, RESET_VAL=4'b1010
//               b: SYNC_STAGES=3, FILTER_CYCLES=4, RESET_VAL=4'b0000
//               c: SYNC_STAGES=2, FILTER_CYCLES=0, RESET_VAL=4'b0000
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avago28_nxsync_filt;

  logic       clk;
  logic       rn_a, rn_b, rn_c;
  logic [3:0] din_a, din_b, din_c;
  logic [3:0] dout_a, rise_a, fall_a;
  logic [3:0] dout_b, rise_b, fall_b;
  logic [3:0] dout_c, rise_c, fall_c;

  int n_checks;
  int n_fail;

  avago28_nxsync_filt #(.NUM_CH(4), .SYNC_STAGES(3), .FILTER_CYCLES(0), .RESET_VAL(4'b1010)) u_dut_a (
    .dstclk(clk), .dstrst_n(rn_a), .data_in(din_a),
    .data_out(dout_a), .rise_pulse(rise_a), .fall_pulse(fall_a));

  avago28_nxsync_filt #(.NUM_CH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(4'b0000)) u_dut_b (
    .dstclk(clk), .dstrst_n(rn_b), .data_in(din_b),
    .data_out(dout_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

  avago28_nxsync_filt #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_VAL(4'b0000)) u_dut_c (
    .dstclk(clk), .dstrst_n(rn_c), .data_in(din_c),
    .data_out(dout_c), .rise_pulse(rise_c), .fall_pulse(fall_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model. For every channel it remembers the input value sampled
  // at each past clock edge. The value reaching the filter at edge e is the
  // input sampled at edge e-K. data_out flips at edge e exactly when the
  // filter-stage values of the last F+1 edges (e-F..e) all differ from the
  // current data_out.
  // --------------------------------------------------------------------------
  logic [15:0] m_hist [3][4];   // bit j = input sampled j+1 edges ago
  logic [3:0]  m_dout [3];
  logic [3:0]  m_rise [3];
  logic [3:0]  m_fall [3];

  function automatic int k_of(input int d);
    return (d == 2) ? 2 : 3;
  endfunction

  function automatic int f_of(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  function automatic logic [3:0] rv_of(input int d);
    return (d == 0) ? 4'b1010 : 4'b0000;
  endfunction

  task automatic model_reset(input int d);
    logic [3:0] rv;
    rv = rv_of(d);
    for (int ch = 0; ch < 4; ch++) m_hist[d][ch] = {16{rv[ch]}};
    m_dout[d] = rv;
    m_rise[d] = 4'b0000;
    m_fall[d] = 4'b0000;
  endtask

  task automatic model_step(input int d, input logic [3:0] din, input logic rn);
    int k, f;
    bit ok;
    if (!rn) begin
      model_reset(d);
      return;
    end
    k = k_of(d);
    f = f_of(d);
    m_rise[d] = 4'b0000;
    m_fall[d] = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      ok = 1'b1;
      for (int j = k - 1; j <= k - 1 + f; j++) begin
        if (m_hist[d][ch][j] == m_dout[d][ch]) ok = 1'b0;
      end
      if (ok) begin
        m_rise[d][ch] = ~m_dout[d][ch];
        m_fall[d][ch] =  m_dout[d][ch];
        m_dout[d][ch] = ~m_dout[d][ch];
      end
      m_hist[d][ch] = {m_hist[d][ch][14:0], din[ch]};
    end
  endtask

  // One clock edge: advance the model at the edge, return at the following
  // falling edge where outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    model_step(0, din_a, rn_a);
    model_step(1, din_b, rn_b);
    model_step(2, din_c, rn_c);
    @(negedge clk);
  endtask

  function automatic logic [3:0] rmask(input int n);
    logic [3:0] m;
    for (int ch = 0; ch < 4; ch++) m[ch] = ($urandom_range(0, n - 1) == 0);
    return m;
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (dout_a !== 4'b1010) begin
      n_fail++; $display("FAIL reset_dout_a: got %b expected %b", dout_a, 4'b1010);
    end
    n_checks++;
    if (rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses_a: got rise=%b fall=%b expected 0000", rise_a, fall_a);
    end
    n_checks++;
    if (dout_b !== 4'b0000) begin
      n_fail++; $display("FAIL reset_dout_b: got %b expected 0000", dout_b);
    end
    rn_a = 1'b1; rn_b = 1'b1; rn_c = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (dout_a !== 4'b1010 || rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
        n_fail++;
        $display("FAIL post_release_a cyc%0d: got out=%b rise=%b fall=%b expected out=1010 no pulses",
                 i, dout_a, rise_a, fall_a);
      end
    end
  endtask

  task automatic test_base_latency();
    din_a = 4'b1011;
    for (int e = 0; e <= 4; e++) begin
      tick();
      n_checks++;
      if (dout_a[0] !== (e >= 3)) begin
        n_fail++; $display("FAIL latency_dout edge%0d: got %b expected %b", e, dout_a[0], (e >= 3));
      end
      n_checks++;
      if (rise_a[0] !== (e == 3) || fall_a !== 4'b0000) begin
        n_fail++; $display("FAIL latency_pulse edge%0d: got rise=%b fall=%b expected rise=%b fall=0000",
                           e, rise_a[0], fall_a, (e == 3));
      end
    end
  endtask

  task automatic test_filter_reject();
    din_b[1] = 1'b1;
    for (int e = 0; e < 15; e++) begin
      if (e == 3) din_b[1] = 1'b0;
      tick();
      n_checks++;
      if (dout_b[1] !== 1'b0 || rise_b[1] !== 1'b0 || fall_b[1] !== 1'b0) begin
        n_fail++; $display("FAIL filter_reject edge%0d: got out=%b rise=%b fall=%b expected 0 0 0",
                           e, dout_b[1], rise_b[1], fall_b[1]);
      end
    end
  endtask

  task automatic test_filter_accept();
    din_b[1] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_checks++;
      if (dout_b[1] !== (e >= 7) || rise_b[1] !== (e == 7) || fall_b[1] !== 1'b0) begin
        n_fail++; $display("FAIL filter_accept_rise edge%0d: got out=%b rise=%b fall=%b expected %b %b 0",
                           e, dout_b[1], rise_b[1], fall_b[1], (e >= 7), (e == 7));
      end
    end
    din_b[1] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_checks++;
      if (dout_b[1] !== (e < 7) || fall_b[1] !== (e == 7) || rise_b[1] !== 1'b0) begin
        n_fail++; $display("FAIL filter_accept_fall edge%0d: got out=%b rise=%b fall=%b expected %b 0 %b",
                           e, dout_b[1], rise_b[1], fall_b[1], (e < 7), (e == 7));
      end
    end
  endtask

  task automatic test_async_reset();
    din_b[1] = 1'b1;
    repeat (5) tick();            // change pending, two disagreements counted
    rn_b = 1'b0;
    model_reset(1);
    #1;
    n_checks++;
    if (dout_b !== 4'b0000 || rise_b !== 4'b0000 || fall_b !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_pending: got out=%b rise=%b fall=%b expected all 0",
                         dout_b, rise_b, fall_b);
    end
    tick();
    rn_b = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_checks++;
      if (dout_b[1] !== (e >= 7) || rise_b[1] !== (e == 7)) begin
        n_fail++; $display("FAIL requalify edge%0d: got out=%b rise=%b expected %b %b",
                           e, dout_b[1], rise_b[1], (e >= 7), (e == 7));
      end
    end
    // Pulse currently high; reset must clear it before the next edge.
    rn_b = 1'b0;
    model_reset(1);
    #1;
    n_checks++;
    if (dout_b !== 4'b0000 || rise_b !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_inflight: got out=%b rise=%b expected 0000 0000", dout_b, rise_b);
    end
    tick();
    rn_b = 1'b1;
    din_b = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_independence();
    din_c = 4'b1111;
    for (int e = 0; e < 4; e++) begin
      tick();
      n_checks++;
      if (rise_c !== ((e == 2) ? 4'b1111 : 4'b0000) || dout_c !== ((e >= 2) ? 4'b1111 : 4'b0000)) begin
        n_fail++; $display("FAIL independence edge%0d: got out=%b rise=%b", e, dout_c, rise_c);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      din_a = din_a ^ rmask(4);
      din_b = din_b ^ rmask(8);
      din_c = din_c ^ rmask(4);
      if (!rn_a) rn_a = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin rn_a = 1'b0; model_reset(0); end
      if (!rn_b) rn_b = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin rn_b = 1'b0; model_reset(1); end
      if (!rn_c) rn_c = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin rn_c = 1'b0; model_reset(2); end
      tick();
      n_checks++;
      if ({dout_a, rise_a, fall_a} !== {m_dout[0], m_rise[0], m_fall[0]}) begin
        n_fail++; $display("FAIL random_a cyc%0d: got %b/%b/%b expected %b/%b/%b",
                           i, dout_a, rise_a, fall_a, m_dout[0], m_rise[0], m_fall[0]);
      end
      n_checks++;
      if ({dout_b, rise_b, fall_b} !== {m_dout[1], m_rise[1], m_fall[1]}) begin
        n_fail++; $display("FAIL random_b cyc%0d: got %b/%b/%b expected %b/%b/%b",
                           i, dout_b, rise_b, fall_b, m_dout[1], m_rise[1], m_fall[1]);
      end
      n_checks++;
      if ({dout_c, rise_c, fall_c} !== {m_dout[2], m_rise[2], m_fall[2]}) begin
        n_fail++; $display("FAIL random_c cyc%0d: got %b/%b/%b expected %b/%b/%b",
                           i, dout_c, rise_c, fall_c, m_dout[2], m_rise[2], m_fall[2]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rn_a = 1'b0; rn_b = 1'b0; rn_c = 1'b0;
    din_a = 4'b1010; din_b = 4'b0000; din_c = 4'b0000;
    model_reset(0);
    model_reset(1);
    model_reset(2);

    test_reset();
    test_base_latency();
    test_filter_reject();
    test_filter_accept();
    test_async_reset();
    test_independence();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_avago28_nxsync_filt
`default_nettype wire
